imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time sequencer for the core's instruction-memory write port (IM_we/IM_addr/IM_data).
//  Takes a byte stream (e.g. from a UART RX) framed as length + payload + checksum, packs it
//  into 32-bit little-endian words and writes them into instruction memory.
//  Holds the CPU in reset until a load completes cleanly; on any error it keeps the CPU in reset.
// PARAMETERS
//  BASE_ADDR      32'h0   byte address of the first instruction word written
//  MAX_WORDS      256     largest accepted word count; a larger count is an error
//  TIMEOUT_CYCLES 100000  idle cycles allowed between bytes in LEN/DATA/CSUM before error
// PORTS
//  clk         in   1   single clock; everything is rising-edge
//  rst         in   1   synchronous, active-high reset
//  load_req    in   1   1-cycle pulse: start (or restart) a load
//  byte_valid  in   1   byte_data is valid this cycle
//  byte_data   in   8   stream byte
//  byte_ready  out  1   loader accepts byte this cycle (transfer = byte_valid & byte_ready)
//  im_we       out  1   instruction-memory write strobe, 1 cycle per word
//  im_addr     out  32  word byte-address, BASE_ADDR + 4*index
//  im_data     out  32  word to write
//  cpu_rst     out  1   reset to core; 1 in every state except DONE
//  done        out  1   load finished, checksum good
//  error       out  1   load failed (oversize, checksum, timeout)
// BEHAVIOUR
//  Reset values: state=IDLE, cpu_rst=1, im_we=0, im_addr=BASE_ADDR, im_data=0, done=0,
//   error=0, byte_ready=0, counters and checksum=0.
//  Frame: 4 length bytes (word count N, LSB first), N*4 payload bytes (each word LSB first),
//   1 checksum byte = XOR of all 4 length bytes and all payload bytes.
//  States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
//  byte_ready = (state in {LEN,DATA,CSUM}) & ~load_req; combinational from registered state.
//  load_req in any state (incl. DONE/ERR): next state LEN, byte/word counters, checksum and
//   timeout cleared, done=0, error=0, cpu_rst=1, im_addr=BASE_ADDR. load_req wins over a
//   byte offered in the same cycle (byte not accepted).
//  IDLE: waits for load_req; ignores bytes.
//  LEN: accepts 4 bytes. After the 4th: N>MAX_WORDS -> ERR; N==0 -> CSUM; else -> DATA.
//  DATA: shifts bytes into a word; after the 4th byte of a word -> WRITE.
//  WRITE: exactly 1 cycle, im_we=1 with the assembled im_data and current im_addr;
//   byte_ready=0. Next cycle: im_addr+=4, word index+1; index==N -> CSUM else DATA.
//  Write latency: im_we asserts the cycle after the 4th byte of the word is accepted.
//  CSUM: accepts 1 byte; equal to running XOR -> DONE, else -> ERR.
//  DONE: done=1, cpu_rst=0, stays until load_req or rst. ERR: error=1, cpu_rst=1, same exit.
//  Timeout: counter increments each cycle in LEN/DATA/CSUM without a transfer, clears on
//   transfer; reaching TIMEOUT_CYCLES -> ERR. Counter does not run in WRITE/IDLE/DONE/ERR.
//  im_we never asserts outside WRITE; im_addr wraps mod 2^32 (no other overflow checks).
//  rst mid-load aborts immediately to reset values; partially written memory not cleaned.
// STRUCTURE
//  Shared package: state encoding (3-bit localparams), LEN_BYTES=4, WORD_BYTES=4.
//  Sub-module word_assembler: byte shift register + 2-bit byte counter, outputs
//   word[31:0] and word_full; cleared by load_req/rst. FSM, address, checksum and
//   timeout logic stay in imem_boot_loader.
// TESTING
//  1 load_req; bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 92 -> im_we @0 data 0x00000013,
//    @4 data 0x00100093; then done=1, cpu_rst=0, error=0.
//  2 same frame, checksum 93 -> no change to writes, error=1, cpu_rst=1, done=0.
//  3 bytes 00 00 00 00 | 00 -> zero im_we pulses, done=1, cpu_rst=0.
//  4 MAX_WORDS=256, length 01 01 00 00 (257) -> error=1 the cycle after 4th byte, no im_we.
//  5 TIMEOUT_CYCLES=16, stop after 2 payload bytes -> error=1 after 16 idle cycles.
//  6 load_req after first word written, then valid 1-word frame -> cpu_rst stays 1 across
//    restart, write @BASE_ADDR with new word, done=1; also check byte with load_req not taken.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// frame geometry and the running checksum step.
package imem_boot_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LEN   = ST_LEN,
        S_DATA  = ST_DATA,
        S_WRITE = ST_WRITE,
        S_CSUM  = ST_CSUM,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_e;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_data
    );
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_full_o flags the
// byte that completes the current word.
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [31:0] word_next_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    assign word_next_o = {byte_i, word_q[31:8]};
    assign word_o      = word_q;
    assign word_full_o = shift_i & ~clr_i & (cnt_q == 2'(WORD_BYTES - 1));

    // Shift-register and byte-counter next state
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = 32'h0000_0000;
            cnt_d  = 2'd0;
        end else if (shift_i) begin
            word_d = word_next_o;
            cnt_d  = cnt_q + 2'd1;
        end else begin
            word_d = word_q;
            cnt_d  = cnt_q;
        end
    end

    // Assembler registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= 32'h0000_0000;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: receives length + payload + XOR checksum frames, writes
// the payload words to instruction memory and releases the core on success.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_req_i,
    imem_boot_loader_if.master  bus,
    output logic                cpu_rst_o,
    output logic                done_o,
    output logic                error_o
);

    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   n_q, n_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     addr_q, addr_d;
    logic            im_we_q, cpu_rst_q, done_q, error_q;

    logic            in_stream_s, xfer_s, shift_s, word_full_s, tmo_hit_s;
    logic [31:0]     asm_word_s, len_word_s;

    assign in_stream_s    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign bus.byte_ready = in_stream_s & ~load_req_i;
    assign xfer_s         = bus.byte_valid & bus.byte_ready;
    assign shift_s        = xfer_s & ((state_q == S_LEN) || (state_q == S_DATA));
    assign tmo_hit_s      = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    imem_boot_loader_word_assembler u_asm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (load_req_i),
        .shift_i     (shift_s),
        .byte_i      (bus.byte_data),
        .word_o      (asm_word_s),
        .word_next_o (len_word_s),
        .word_full_o (word_full_s)
    );

    assign bus.im_we   = im_we_q;
    assign bus.im_addr = addr_q;
    assign bus.im_data = asm_word_s;
    assign cpu_rst_o   = cpu_rst_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

    // FSM next state, counters, checksum and timeout
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        if (load_req_i) begin
            state_d = S_LEN;
            n_d     = {IW{1'b0}};
            idx_d   = {IW{1'b0}};
            csum_d  = 8'h00;
            tmo_d   = {TW{1'b0}};
            addr_d  = BASE_ADDR;
        end else begin
            case (state_q)
                S_LEN, S_DATA, S_CSUM: begin
                    if (!xfer_s) begin
                        if (tmo_hit_s) begin
                            state_d = S_ERR;
                        end else begin
                            tmo_d = tmo_q + TW'(1);
                        end
                    end else begin
                        tmo_d = {TW{1'b0}};
                        case (state_q)
                            S_LEN: begin
                                csum_d = csum_step(csum_q, bus.byte_data);
                                if (word_full_s) begin
                                    if (len_word_s > 32'(MAX_WORDS)) begin
                                        state_d = S_ERR;
                                    end else if (len_word_s == 32'h0000_0000) begin
                                        state_d = S_CSUM;
                                    end else begin
                                        n_d     = len_word_s[IW-1:0];
                                        state_d = S_DATA;
                                    end
                                end else begin
                                    state_d = S_LEN;
                                end
                            end
                            S_DATA: begin
                                csum_d = csum_step(csum_q, bus.byte_data);
                                if (word_full_s) begin
                                    state_d = S_WRITE;
                                end else begin
                                    state_d = S_DATA;
                                end
                            end
                            default: begin
                                if (bus.byte_data == csum_q) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_ERR;
                                end
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    addr_d = addr_q + 32'd4;
                    idx_d  = idx_q + IW'(1);
                    if ((idx_q + IW'(1)) == n_q) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_IDLE, S_DONE, S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            n_q       <= {IW{1'b0}};
            idx_q     <= {IW{1'b0}};
            csum_q    <= 8'h00;
            tmo_q     <= {TW{1'b0}};
            addr_q    <= BASE_ADDR;
            im_we_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            addr_q    <= addr_d;
            im_we_q   <= (state_d == S_WRITE);
            cpu_rst_q <= (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst;
    logic load_req;
    logic cpu_rst, done, error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_WORDS      (256),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_req_i (load_req),
        .bus        (bus),
        .cpu_rst_o  (cpu_rst),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every im_we cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr %h data %h", bus.im_addr, bus.im_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.im_addr !== e.addr || bus.im_data !== e.data) begin
                    failures++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             bus.im_addr, bus.im_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        while (!bus.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] f1[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        logic [7:0] f2[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
        logic [7:0] f3[] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] f4[] = '{8'h01, 8'h01, 8'h00, 8'h00};
        logic [7:0] f5[] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        logic [7:0] f6a[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        logic [7:0] f6b[] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};

        rst = 1'b1;
        load_req = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_im_we", {31'd0, bus.im_we}, 32'd0);
        chk("rst_im_addr", bus.im_addr, 32'h0000_0000);
        chk("rst_im_data", bus.im_data, 32'h0000_0000);
        chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // IDLE ignores offered bytes
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;

        // Test 1: good two-word frame
        pulse_load();
        push_wr(32'h0000_0000, 32'h0000_0013);
        push_wr(32'h0000_0004, 32'h0010_0093);
        send_byte(f1[0]);
        chk("t1_cpu_rst_loading", {31'd0, cpu_rst}, 32'd1);
        for (int i = 1; i < 13; i++) send_byte(f1[i]);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_writes_seen", exp_q.size(), 32'd0);

        // Test 2: same frame, bad checksum
        pulse_load();
        chk("t2_done_cleared", {31'd0, done}, 32'd0);
        chk("t2_cpu_rst_restart", {31'd0, cpu_rst}, 32'd1);
        push_wr(32'h0000_0000, 32'h0000_0013);
        push_wr(32'h0000_0004, 32'h0010_0093);
        send_seq(f2);
        chk("t2_error", {31'd0, error}, 32'd1);
        chk("t2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("t2_done", {31'd0, done}, 32'd0);
        chk("t2_writes_seen", exp_q.size(), 32'd0);

        // Test 3: empty frame
        pulse_load();
        chk("t3_error_cleared", {31'd0, error}, 32'd0);
        send_seq(f3);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // Test 4: oversize length 257
        pulse_load();
        send_seq(f4);
        chk("t4_error", {31'd0, error}, 32'd1);
        chk("t4_done", {31'd0, done}, 32'd0);
        chk("t4_ready_in_err", {31'd0, bus.byte_ready}, 32'd0);

        // Test 5: timeout after two payload bytes
        pulse_load();
        send_seq(f5);
        repeat (15) @(posedge clk);
        #1;
        chk("t5_no_error_yet", {31'd0, error}, 32'd0);
        @(posedge clk);
        #1;
        chk("t5_timeout_error", {31'd0, error}, 32'd1);
        chk("t5_cpu_rst", {31'd0, cpu_rst}, 32'd1);

        // Test 6: restart after first word is written
        pulse_load();
        push_wr(32'h0000_0000, 32'h0000_0013);
        send_seq(f6a);
        @(posedge clk);
        #1;
        chk("t6_writes_seen_a", exp_q.size(), 32'd0);
        chk("t6_cpu_rst_mid", {31'd0, cpu_rst}, 32'd1);
        load_req = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h55;
        @(negedge clk);
        chk("t6_ready_during_load_req", {31'd0, bus.byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        bus.byte_valid = 1'b0;
        chk("t6_cpu_rst_restart", {31'd0, cpu_rst}, 32'd1);
        chk("t6_addr_restart", bus.im_addr, 32'h0000_0000);
        push_wr(32'h0000_0000, 32'h1234_5678);
        send_seq(f6b);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("t6_error", {31'd0, error}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_writes_seen", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
